// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC with one shared period counter and double-buffered per-channel duties.
// Latency: pwm_out is registered one cycle after the counter value it reflects.
// No backpressure: shadow writes are always accepted; period, mode and duties switch only at a wrap.
module pwm_dac_multi #(
  parameter int width    = 9,
  parameter int channels = 4,
  localparam int ch_w    = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [width-1:0]    period,
  input  logic                center_mode,
  input  logic [channels-1:0] invert,
  input  logic                wr_en,
  input  logic [ch_w-1:0]     wr_ch,
  input  logic [width-1:0]    wr_duty,
  output logic [channels-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0]    counter;
  logic [width-1:0]    counter_nxt;
  logic                dir_down;
  logic                dir_down_nxt;
  logic                wrap;
  logic [width-1:0]    act_period;
  logic                act_center;
  logic [width-1:0]    shadow [channels];
  logic [width-1:0]    active [channels];
  logic [channels-1:0] raw;

  // Next counter value, direction and wrap detection for the active mode
  always_comb begin
    counter_nxt  = counter;
    dir_down_nxt = dir_down;
    wrap         = 1'b0;
    if (enable) begin
      if (!act_center) begin
        // Edge-aligned: 0..P then back to 0; P=0 wraps every cycle
        if (counter >= act_period) wrap = 1'b1;
        else                       counter_nxt = counter + one;
      end else if (!dir_down) begin
        // Center-aligned rising half; P<=1 has no falling half
        if (counter < act_period)    counter_nxt = counter + one;
        else if (act_period <= one)  wrap = 1'b1;
        else begin
          dir_down_nxt = 1'b1;
          counter_nxt  = act_period - one;
        end
      end else begin
        // Center-aligned falling half ends at 1 so 0 is not repeated
        if (counter > one) counter_nxt = counter - one;
        else               wrap = 1'b1;
      end
      if (wrap) begin
        counter_nxt  = '0;
        dir_down_nxt = 1'b0;
      end
    end
  end

  // Counter, direction and the period/mode latched at each wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter    <= '0;
      dir_down   <= 1'b0;
      act_period <= '0;
      act_center <= 1'b0;
    end else begin
      counter  <= counter_nxt;
      dir_down <= dir_down_nxt;
      if (wrap) begin
        act_period <= period;
        act_center <= center_mode;
      end
    end
  end

  // Shadow duties take writes any time; active duties copy the pre-write shadow at a wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < channels; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < channels; i++) begin
        if (wrap) active[i] <= shadow[i];
        if (wr_en && (wr_ch == ch_w'(i))) shadow[i] <= wr_duty;
      end
    end
  end

  // Per-channel unsigned compare of counter against the active duty
  always_comb begin
    raw = '0;
    for (int i = 0; i < channels; i++) begin
      raw[i] = (counter < active[i]);
    end
  end

  // Registered outputs; polarity follows invert live, independent of enable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= raw ^ invert;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi (width=9, channels=4).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Per-period high counts and a ch2 bit pattern are gathered and compared to hand-derived values.
module tb_pwm_dac_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [8:0] period;
  logic       center_mode;
  logic [3:0] invert;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [8:0] wr_duty;
  logic [3:0] pwm_out;
  logic       period_start;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         hi_cnt [4];
  int         ps_cnt;
  logic [7:0] pat2;

  pwm_dac_multi #(.width(9), .channels(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period       (period),
    .center_mode  (center_mode),
    .invert       (invert),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    ps_cnt = 0;
    pat2   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
    if (period_start) ps_cnt++;
    pat2 = {pat2[6:0], pwm_out[2]};
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [8:0] duty);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = duty;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (period_start) break;
    end
    check(tag, period_start, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; period = 9'd9; center_mode = 1'b0;
    invert = 4'b0000; wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 9'd0;
    clear_counts();

    // 1. Reset state, then edge mode P=9 with ch0=3, ch1=0
    run(3);
    check("rst_pwm", pwm_out, 4'b0000);
    check("rst_ps", period_start, 0);
    reset_n = 1'b1; enable = 1'b0;
    wr(2'd0, 9'd3);
    wr(2'd1, 9'd0);
    check("idle_ps", period_start, 0);
    check("idle_pwm", pwm_out, 4'b0000);
    enable = 1'b1;
    tick();                              // P=0 after reset: first enabled edge wraps
    check("first_wrap_ps", period_start, 1);
    clear_counts(); run(10);
    check("p1_ch0_hi", hi_cnt[0], 3);
    check("p1_ch1_hi", hi_cnt[1], 0);
    check("p1_ps_cnt", ps_cnt, 1);
    check("p1_ps_end", period_start, 1);
    clear_counts(); run(10);
    check("p2_ch0_hi", hi_cnt[0], 3);
    check("p2_ps_cnt", ps_cnt, 1);

    // 2. Mid-period write at counter 5, then a write coincident with the wrap
    clear_counts(); run(5);
    wr(2'd0, 9'd7);
    run(4);
    check("mid_cur_ch0", hi_cnt[0], 3);
    check("mid_cur_ps", period_start, 1);
    clear_counts(); run(10);
    check("mid_next_ch0", hi_cnt[0], 7);
    clear_counts(); run(9);
    wr(2'd0, 9'd2);                      // this edge is the wrap edge
    check("coinc_ps", period_start, 1);
    check("coinc_cur_ch0", hi_cnt[0], 7);
    clear_counts(); run(10);
    check("coinc_defer_ch0", hi_cnt[0], 7);
    clear_counts(); run(10);
    check("coinc_apply_ch0", hi_cnt[0], 2);

    // 3. Center mode P=4, ch2 duty 2: counter 0,1,2,3,4,3,2,1
    center_mode = 1'b1; period = 9'd4;
    wr(2'd2, 9'd2);
    wait_ps("ctr_wrap", 30);
    clear_counts(); run(8);
    check("ctr_ch2_pattern", pat2, 8'b1100_0001);
    check("ctr_ps_cnt", ps_cnt, 1);
    check("ctr_ps_end", period_start, 1);
    check("ctr_ch0_hi", hi_cnt[0], 3);

    // 4. Boundaries in edge mode P=9
    period = 9'd9; center_mode = 1'b0;
    wr(2'd0, 9'd10);
    wr(2'd1, 9'd511);
    wr(2'd2, 9'd9);
    wr(2'd3, 9'd0);
    invert = 4'b1000;
    wait_ps("bnd_wrap", 30);
    clear_counts(); run(10);
    check("bnd_duty10_hi", hi_cnt[0], 10);
    check("bnd_duty511_hi", hi_cnt[1], 10);
    check("bnd_duty9_hi", hi_cnt[2], 9);
    check("bnd_inv_duty0_hi", hi_cnt[3], 10);
    check("bnd_ps_cnt", ps_cnt, 1);
    invert = 4'b0000; tick();
    check("inv_off", pwm_out, 4'b0111);
    invert = 4'b1001; tick();
    check("inv_on", pwm_out, 4'b1110);
    invert = 4'b1000;

    // 5. Enable low for 5 cycles at counter 2, with a shadow write during the hold
    enable = 1'b0;
    clear_counts();
    run(2);
    wr(2'd2, 9'd4);
    run(2);
    check("hold_ps_cnt", ps_cnt, 0);
    check("hold_ch2_hi", hi_cnt[2], 5);
    check("hold_pwm", pwm_out, 4'b1111);
    enable = 1'b1;
    clear_counts(); run(8);
    check("resume_ps_cnt", ps_cnt, 1);
    check("resume_ps_end", period_start, 1);
    check("resume_ch2_hi", hi_cnt[2], 7);
    center_mode = 1'b1; period = 9'd8;   // must not disturb the running period
    clear_counts(); run(10);
    check("held_write_ch2", hi_cnt[2], 4);
    check("late_cfg_ps_cnt", ps_cnt, 1);
    check("late_cfg_ps_end", period_start, 1);

    // 6. Reset at counter 6 in center mode P=8
    clear_counts(); run(6);
    check("pre_rst_pwm", pwm_out, 4'b1011);
    check("pre_rst_ps_cnt", ps_cnt, 0);
    reset_n = 1'b0; invert = 4'b0000;
    tick();
    check("mid_rst_pwm", pwm_out, 4'b0000);
    check("mid_rst_ps", period_start, 0);
    reset_n = 1'b1; period = 9'd3; center_mode = 1'b0;
    wr(2'd0, 9'd2);                      // coincides with the first post-reset wrap
    check("post_rst_ps", period_start, 1);
    check("post_rst_pwm", pwm_out, 4'b0000);
    clear_counts(); run(4);
    check("post_rst_p1_ch0", hi_cnt[0], 0);
    check("post_rst_p1_ps", ps_cnt, 1);
    check("post_rst_p1_end", period_start, 1);
    clear_counts(); run(4);
    check("post_rst_p2_ch0", hi_cnt[0], 2);
    check("post_rst_p2_ps", ps_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
